// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: byte-masked stores and full-word loads on a word array.
// Optional macro DMEM_ALIGN_CHECK_EN flags misaligned requests as errors.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_address,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        dmem_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [AW+1:0]   r_addr;
  logic [3:0]      r_wmask;
  logic [31:0]     r_wdata;
  logic            r_op_read;
  logic            r_op_write;
  logic            r_resp;
  logic            r_err;
  logic            r_rd_en;
  logic [31:0]     r_rd_q;
  logic [31:0]     r_mem [DEPTH];

  logic            w_accept;
  logic            w_enter_resp;
  logic [AW+1:0]   w_src_addr;
  logic [3:0]      w_src_wmask;
  logic [31:0]     w_src_wdata;
  logic            w_src_read;
  logic            w_src_write;
  logic [AW-1:0]   w_src_idx;
  logic            w_misalign;
  logic            w_src_err;
  logic            w_commit;
  logic            w_unused_bits;

  assign w_accept = (r_state == IDLE) && (dmem_read || dmem_write);

  // With single-cycle latency the response is produced on the accepting edge,
  // so the live request feeds the memory instead of the captured copy.
  generate
    if (LATENCY == 1) begin : g_src_direct
      assign w_enter_resp = w_accept;
      assign w_src_addr   = dmem_address[AW+1:0];
      assign w_src_wmask  = dmem_wmask;
      assign w_src_wdata  = dmem_wdata;
      assign w_src_read   = dmem_read;
      assign w_src_write  = dmem_write;
    end else begin : g_src_captured
      assign w_enter_resp = (r_state == WAIT) && (r_cnt == '0);
      assign w_src_addr   = r_addr;
      assign w_src_wmask  = r_wmask;
      assign w_src_wdata  = r_wdata;
      assign w_src_read   = r_op_read;
      assign w_src_write  = r_op_write;
    end
  endgenerate

  assign w_src_idx = w_src_addr[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_misalign    = (w_src_addr[1:0] != 2'b00);
  assign w_unused_bits = ^dmem_address[31:AW+2];
`else
  assign w_misalign    = 1'b0;
  assign w_unused_bits = ^{dmem_address[31:AW+2], w_src_addr[1:0]};
`endif

  assign w_src_err = (w_src_read && w_src_write) || w_misalign;
  // rst gates the commit so a reset landing on the RESP edge aborts the store
  assign w_commit  = w_enter_resp && !rst && w_src_write && !w_src_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wmask    <= '0;
      r_wdata    <= '0;
      r_op_read  <= 1'b0;
      r_op_write <= 1'b0;
      r_resp     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_en    <= 1'b0;
    end else begin
      r_resp  <= w_enter_resp;
      r_err   <= w_enter_resp && w_src_err;
      r_rd_en <= w_enter_resp && w_src_read && !w_src_err;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr     <= dmem_address[AW+1:0];
            r_wmask    <= dmem_wmask;
            r_wdata    <= dmem_wdata;
            r_op_read  <= dmem_read;
            r_op_write <= dmem_write;
            r_cnt      <= CW'(LATENCY - 1);
            r_state    <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Memory port kept reset-free so it maps onto block RAM with byte enables.
  always_ff @(posedge clk) begin
    if (w_enter_resp) begin
      r_rd_q <= r_mem[w_src_idx];
    end
    for (int i = 0; i < 4; i++) begin
      if (w_commit && w_src_wmask[i]) begin
        r_mem[w_src_idx][i*8 +: 8] <= w_src_wdata[i*8 +: 8];
      end
    end
  end

  assign dmem_resp  = r_resp;
  assign dmem_err   = r_err;
  assign dmem_rdata = r_rd_en ? r_rd_q : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=2, DEPTH=256) with immediate-assertion checks.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        dmem_err;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH(256), .LATENCY(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .dmem_address (dmem_address),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_wmask   (dmem_wmask),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .dmem_err     (dmem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction: accept edge N, response expected after edge N+2, gone after N+3.
  task automatic req(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [3:0] mask, input logic [31:0] wd,
                     input logic chk_rd, input logic [31:0] exp_rd, input logic exp_err);
    @(negedge clk);
    dmem_read    = rd;
    dmem_write   = wr;
    dmem_address = addr;
    dmem_wmask   = mask;
    dmem_wdata   = wd;
    @(posedge clk); #1;
    chk({tag, " resp@N"}, {31'b0, dmem_resp}, 32'd0);
    @(posedge clk); #1;
    chk({tag, " resp@N+1"}, {31'b0, dmem_resp}, 32'd0);
    @(posedge clk); #1;
    chk({tag, " resp@N+2"}, {31'b0, dmem_resp}, 32'd1);
    chk({tag, " err"}, {31'b0, dmem_err}, {31'b0, exp_err});
    if (chk_rd) chk({tag, " rdata"}, dmem_rdata, exp_rd);
    $display("txn %s rd=%0b wr=%0b addr=%h mask=%b wdata=%h -> resp=%0b err=%0b rdata=%h",
             tag, rd, wr, addr, mask, wd, dmem_resp, dmem_err, dmem_rdata);
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    @(posedge clk); #1;
    chk({tag, " resp@N+3"}, {31'b0, dmem_resp}, 32'd0);
    chk({tag, " rdata idle"}, dmem_rdata, 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    dmem_address = 32'h0;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_wmask   = 4'h0;
    dmem_wdata   = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset resp", {31'b0, dmem_resp}, 32'd0);
    chk("reset err", {31'b0, dmem_err}, 32'd0);
    chk("reset rdata", dmem_rdata, 32'd0);
    rst = 1'b0;

    req("wr10_full",  1'b0, 1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    req("rd10",       1'b1, 1'b0, 32'h0000_0010, 4'b0000, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0);
    req("wr10_lane1", 1'b0, 1'b1, 32'h0000_0010, 4'b0010, 32'h0000_5500, 1'b0, 32'h0, 1'b0);
    req("rd10_merge", 1'b1, 1'b0, 32'h0000_0010, 4'b0000, 32'h0,         1'b1, 32'hDEAD_55EF, 1'b0);
    req("rd410_wrap", 1'b1, 1'b0, 32'h0000_0410, 4'b0000, 32'h0,         1'b1, 32'hDEAD_55EF, 1'b0);
    req("rd_highbits",1'b1, 1'b0, 32'hFFFF_F410, 4'b0000, 32'h0,         1'b1, 32'hDEAD_55EF, 1'b0);

    req("wr40_zero",  1'b0, 1'b1, 32'h0000_0040, 4'b1111, 32'h0000_0000, 1'b0, 32'h0, 1'b0);
    req("wr40_lane3", 1'b0, 1'b1, 32'h0000_0040, 4'b1000, 32'hABCD_EF01, 1'b0, 32'h0, 1'b0);
    req("rd40",       1'b1, 1'b0, 32'h0000_0040, 4'b0000, 32'h0,         1'b1, 32'hAB00_0000, 1'b0);

    req("wr20",       1'b0, 1'b1, 32'h0000_0020, 4'b1111, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
    req("rw20_err",   1'b1, 1'b1, 32'h0000_0020, 4'b1111, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1);
    req("rd20_after_rw",  1'b1, 1'b0, 32'h0000_0020, 4'b0000, 32'h0,     1'b1, 32'h1234_5678, 1'b0);
    req("wr20_nomask",    1'b0, 1'b1, 32'h0000_0020, 4'b0000, 32'h0000_0000, 1'b0, 32'h0, 1'b0);
    req("rd20_after_nomask", 1'b1, 1'b0, 32'h0000_0020, 4'b0000, 32'h0, 1'b1, 32'h1234_5678, 1'b0);

    // Store aborted by reset during WAIT
    req("wr30",       1'b0, 1'b1, 32'h0000_0030, 4'b1111, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    dmem_write   = 1'b1;
    dmem_address = 32'h0000_0030;
    dmem_wmask   = 4'b1111;
    dmem_wdata   = 32'h1111_1111;
    @(posedge clk); #1;
    chk("abort resp@N", {31'b0, dmem_resp}, 32'd0);
    @(negedge clk);
    rst        = 1'b1;
    dmem_write = 1'b0;
    #1;
    chk("abort rst resp", {31'b0, dmem_resp}, 32'd0);
    chk("abort rst rdata", dmem_rdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort no resp", {31'b0, dmem_resp}, 32'd0);
    end
    $display("txn abort wr30 data=11111111 reset in WAIT -> resp=%0b", dmem_resp);
    req("rd30_after_abort", 1'b1, 1'b0, 32'h0000_0030, 4'b0000, 32'h0, 1'b1, 32'hA5A5_A5A5, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
    req("rd12_misalign", 1'b1, 1'b0, 32'h0000_0012, 4'b0000, 32'h0, 1'b1, 32'h0, 1'b1);
`else
    req("rd12_lowbits",  1'b1, 1'b0, 32'h0000_0012, 4'b0000, 32'h0, 1'b1, 32'hDEAD_55EF, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
